// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, constants and frame helpers for spi_master
// Contents:
//   spi_state_e   transaction FSM states
//   SPI_MAX_BYTES largest address or data byte count honoured
//   SPI_BIT_CNT_W width of the bit counter (holds 0..64)
//   clamp_nbyte   saturates a requested byte count to SPI_MAX_BYTES
//   build_frame   packs address and data bytes into a left-aligned 64-bit frame
package spi_pkg;

  localparam int SPI_MAX_BYTES = 4;
  localparam int SPI_BIT_CNT_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } spi_state_e;

  function automatic logic [2:0] clamp_nbyte(input logic [3:0] n);
    return (n > 4'(SPI_MAX_BYTES)) ? 3'(SPI_MAX_BYTES) : n[2:0];
  endfunction

  // The frame is left-aligned so the first bit on the wire is always bit 63.
  // Address bytes come first, then data bytes, each MSB first.
  function automatic logic [63:0] build_frame(input logic [31:0] addr,
                                              input logic [31:0] data,
                                              input logic [2:0]  na,
                                              input logic [2:0]  nd);
    logic [63:0] a_ext;
    logic [63:0] d_ext;
    logic [63:0] f;
    logic [6:0]  nbits;
    a_ext = {32'h0, addr} & ~({64{1'b1}} << {na, 3'b000});
    d_ext = {32'h0, data} & ~({64{1'b1}} << {nd, 3'b000});
    f     = (a_ext << {nd, 3'b000}) | d_ext;
    nbits = 7'({na, 3'b000}) + 7'({nd, 3'b000});
    return f << (7'd64 - nbits);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - system-side request/status and SPI pin bundle for spi_master
// Modports:
//   master  the spi_master itself: takes requests and miso, drives pins and status
//   slave   the counterpart: issues requests, supplies miso, observes pins and status
interface spi_master_if;

  logic        start;
  logic [3:0]  add_nbyte;
  logic [3:0]  data_nbyte;
  logic [31:0] address_i;
  logic [31:0] data_i;
  logic        miso;
  logic        sclk;
  logic        spi_cs;
  logic        mosi;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;

  modport master (
    input  start, add_nbyte, data_nbyte, address_i, data_i, miso,
    output sclk, spi_cs, mosi, busy, done, rx_data
  );

  modport slave (
    output start, add_nbyte, data_nbyte, address_i, data_i, miso,
    input  sclk, spi_cs, mosi, busy, done, rx_data
  );

endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - sclk divider for spi_master, running only while enabled
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   en            run the divider; when low sclk is forced low and the phase restarts
//   sclk          SPI clock level, low phase first after enable
//   fall_stb      first cycle of each low phase
//   rise_end_stb  last cycle of each high phase
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic fall_stb,
  output logic rise_end_stb
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          phase_last;

  assign phase_last = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (phase_last) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk         = sclk_q;
  assign fall_stb     = en & ~sclk_q & (div_q == '0);
  assign rise_end_stb = en & sclk_q & phase_last;

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master sending address then data bytes, MSB first
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         spi_master_if.master: start/byte counts/address/data in,
//               sclk/spi_cs/mosi/busy/done/rx_data out, miso in
// Parameters: CLK_DIV (sclk half period, >=2), CS_SETUP (>=1), CS_HOLD (>=1)
// Optional receive capture: SPI_MASTER_RX_EN
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CS_CW  = $clog2(CS_MAX + 1);

  spi_state_e               state_q, state_d;
  logic [CS_CW-1:0]         cs_cnt_q, cs_cnt_d;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SPI_BIT_CNT_W-1:0] nbits_q, nbits_d;
  logic [63:0]              tx_sr_q, tx_sr_d;
  logic                     mosi_hold_q, mosi_hold_d;

  logic [2:0]  na_c, nd_c;
  logic [63:0] frame_c;
  logic        accept;
  logic        trail_last;
  logic        active;
  logic        mosi_int;
  logic        sclk_w, fall_stb, rise_end_stb;

  assign na_c       = clamp_nbyte(bus.add_nbyte);
  assign nd_c       = clamp_nbyte(bus.data_nbyte);
  assign frame_c    = build_frame(bus.address_i, bus.data_i, na_c, nd_c);
  assign accept     = (state_q == IDLE) && bus.start;
  assign trail_last = (state_q == TRAIL) && (cs_cnt_q == CS_CW'(CS_HOLD - 1));
  assign active     = (state_q == LEAD) || (state_q == SHIFT) || (state_q == TRAIL);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (state_q == SHIFT),
    .sclk         (sclk_w),
    .fall_stb     (fall_stb),
    .rise_end_stb (rise_end_stb)
  );

  // The shift register advances at the end of a high phase, but the pin only
  // takes the new bit at the following low-phase start; in between (and in
  // LEAD/TRAIL) the held value keeps mosi still.
  assign mosi_int = fall_stb ? tx_sr_q[63] : mosi_hold_q;

  always_comb begin
    state_d     = state_q;
    cs_cnt_d    = cs_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    nbits_d     = nbits_q;
    tx_sr_d     = tx_sr_q;
    mosi_hold_d = mosi_int;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          nbits_d     = 7'({na_c, 3'b000}) + 7'({nd_c, 3'b000});
          tx_sr_d     = frame_c;
          mosi_hold_d = frame_c[63];
          cs_cnt_d    = '0;
          bit_cnt_d   = '0;
          state_d     = LEAD;
        end
      end
      LEAD: begin
        if (cs_cnt_q == CS_CW'(CS_SETUP - 1)) begin
          cs_cnt_d = '0;
          state_d  = (nbits_q == '0) ? TRAIL : SHIFT;
        end else begin
          cs_cnt_d = cs_cnt_q + CS_CW'(1);
        end
      end
      SHIFT: begin
        if (rise_end_stb) begin
          tx_sr_d   = {tx_sr_q[62:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 7'd1;
          if (bit_cnt_q == nbits_q - 7'd1) begin
            state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (trail_last) begin
          state_d = DONE;
        end else begin
          cs_cnt_d = cs_cnt_q + CS_CW'(1);
        end
      end
      DONE: begin
        mosi_hold_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cs_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      nbits_q     <= '0;
      tx_sr_q     <= '0;
      mosi_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_cnt_q    <= cs_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      nbits_q     <= nbits_d;
      tx_sr_q     <= tx_sr_d;
      mosi_hold_q <= mosi_hold_d;
    end
  end

`ifdef SPI_MASTER_RX_EN
  // Only the newest 32 received bits can ever reach rx_data, so the capture
  // window is 32 bits; clearing it at start gives zero-extension for short frames.
  logic [31:0] rx_sr_q, rx_sr_d;
  logic [31:0] rx_data_q, rx_data_d;

  always_comb begin
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    if (accept) begin
      rx_sr_d = '0;
    end else if (rise_end_stb) begin
      rx_sr_d = {rx_sr_q[30:0], bus.miso};
    end
    // Loaded on the way into DONE so the word is valid alongside done.
    if (trail_last) begin
      rx_data_d = rx_sr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr_q   <= '0;
      rx_data_q <= '0;
    end else begin
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign bus.rx_data = rx_data_q;
`else
  assign bus.rx_data = '0;
`endif

  assign bus.sclk   = sclk_w;
  assign bus.spi_cs = active;
  assign bus.busy   = active;
  assign bus.done   = (state_q == DONE);
  assign bus.mosi   = active & mosi_int;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized self-checking bench for spi_master with miso looped to mosi
module tb_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   exp_bits[$];

  always #5 clk = ~clk;

  spi_master_if bus ();
  assign bus.miso = bus.mosi;

  spi_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  function automatic int clampn(input int n);
    return (n > 4) ? 4 : n;
  endfunction

  // Reference frame: address bytes then data bytes, MSB first.
  task automatic make_bits(input logic [31:0] a, input logic [31:0] d, input int na, input int nd);
    exp_bits.delete();
    for (int i = 8 * na - 1; i >= 0; i--) exp_bits.push_back(a[i]);
    for (int i = 8 * nd - 1; i >= 0; i--) exp_bits.push_back(d[i]);
  endtask

  // With loopback the receive word is the last min(N,32) transmitted bits.
  function automatic logic [31:0] model_rx();
    logic [31:0] r;
    int n, k;
    r = 32'h0;
`ifdef SPI_MASTER_RX_EN
    n = exp_bits.size();
    k = (n > 32) ? 32 : n;
    for (int i = n - k; i < n; i++) r = {r[30:0], exp_bits[i]};
`endif
    return r;
  endfunction

  // rej_edge_in: 0 none, >0 clock edge at which a second start is sampled,
  // -1 the edge leaving DONE, -2 a random edge inside the transaction.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] na_raw, input logic [3:0] nd_raw,
                         input int rej_edge_in, input string tag);
    int na, nd, n, exp_done, c, rises, dones, rej_edge;
    logic prev_sclk, prev_mosi;
    logic [31:0] rx_exp;
    bit got[$];
    na = clampn(int'(na_raw));
    nd = clampn(int'(nd_raw));
    make_bits(a, d, na, nd);
    n        = exp_bits.size();
    exp_done = CS_SETUP + 2 * CLK_DIV * n + CS_HOLD + 1;
    rx_exp   = model_rx();
    if (rej_edge_in == -1)      rej_edge = exp_done + 1;
    else if (rej_edge_in == -2) rej_edge = $urandom_range(2, exp_done - 1);
    else                        rej_edge = rej_edge_in;

    @(negedge clk);
    bus.start = 1'b1; bus.address_i = a; bus.data_i = d;
    bus.add_nbyte = na_raw; bus.data_nbyte = nd_raw;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1; prev_sclk = 1'b0; prev_mosi = 1'b0; rises = 0; dones = 0;
    while (c <= exp_done + 40) begin
      if (c == 1) begin
        checks++;
        if (bus.spi_cs !== 1'b1 || bus.busy !== 1'b1 || bus.sclk !== 1'b0)
          begin errors++; $display("FAIL %s first_cycle: cs=%b busy=%b sclk=%b expected 1 1 0", tag, bus.spi_cs, bus.busy, bus.sclk); end
        if (n > 0) begin
          checks++;
          if (bus.mosi !== exp_bits[0])
            begin errors++; $display("FAIL %s first_bit: mosi=%b expected %b", tag, bus.mosi, exp_bits[0]); end
        end
      end
      checks++;
      if (bus.spi_cs === 1'b0 && bus.mosi !== 1'b0)
        begin errors++; $display("FAIL %s mosi_idle cycle %0d: mosi=%b expected 0", tag, c, bus.mosi); end
      if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        if (got.size() < 64) got.push_back(bus.mosi);
      end
      if (bus.sclk === 1'b1 && prev_sclk === 1'b1) begin
        checks++;
        if (bus.mosi !== prev_mosi)
          begin errors++; $display("FAIL %s mosi_stable cycle %0d: mosi=%b expected %b", tag, c, bus.mosi, prev_mosi); end
      end
      if (c < exp_done) begin
        checks++;
        if (bus.spi_cs !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0)
          begin errors++; $display("FAIL %s framing cycle %0d: cs=%b busy=%b done=%b expected 1 1 0", tag, c, bus.spi_cs, bus.busy, bus.done); end
      end else if (c == exp_done) begin
        checks++;
        if (bus.done !== 1'b1 || bus.spi_cs !== 1'b0 || bus.busy !== 1'b0)
          begin errors++; $display("FAIL %s done_cycle %0d: done=%b cs=%b busy=%b expected 1 0 0", tag, c, bus.done, bus.spi_cs, bus.busy); end
        checks++;
        if (bus.rx_data !== rx_exp)
          begin errors++; $display("FAIL %s rx_data: got %h expected %h", tag, bus.rx_data, rx_exp); end
      end else begin
        checks++;
        if (bus.spi_cs !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sclk !== 1'b0)
          begin errors++; $display("FAIL %s after_done cycle %0d: cs=%b busy=%b done=%b sclk=%b expected 0 0 0 0", tag, c, bus.spi_cs, bus.busy, bus.done, bus.sclk); end
      end
      if (bus.done === 1'b1) dones++;
      if (rej_edge > 0 && c == rej_edge - 1) begin
        bus.start = 1'b1; bus.address_i = ~a; bus.data_i = ~d;
        bus.add_nbyte = 4'd4; bus.data_nbyte = 4'd4;
      end
      if (rej_edge > 0 && c == rej_edge) bus.start = 1'b0;
      prev_sclk = bus.sclk;
      prev_mosi = bus.mosi;
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
    checks++;
    if (dones != 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", tag, dones); end
    checks++;
    if (rises != n) begin errors++; $display("FAIL %s sclk_rises: got %0d expected %0d", tag, rises, n); end
    for (int i = 0; i < n && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_bits[i])
        begin errors++; $display("FAIL %s bit %0d: got %b expected %b", tag, i, got[i], exp_bits[i]); end
    end
    checks++;
    if (bus.rx_data !== rx_exp)
      begin errors++; $display("FAIL %s rx_hold: got %h expected %h", tag, bus.rx_data, rx_exp); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.sclk !== 1'b0 || bus.spi_cs !== 1'b0 || bus.mosi !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL reset_outputs: sclk=%b cs=%b mosi=%b busy=%b done=%b expected all 0", bus.sclk, bus.spi_cs, bus.mosi, bus.busy, bus.done); end
    checks++;
    if (bus.rx_data !== 32'h0) begin errors++; $display("FAIL reset_rx: got %h expected 0", bus.rx_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.spi_cs !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL reset_idle: cs=%b busy=%b expected 0 0", bus.spi_cs, bus.busy); end
  endtask

  task automatic test_defaults();
    run_txn(32'h0000_00A5, 32'h0000_003C, 4'd1, 4'd1, 0, "defaults");
  endtask

  task automatic test_clamp();
    run_txn(32'h1234_5678, 32'h9ABC_DEF0, 4'd7, 4'd4, 0, "clamp");
  endtask

  task automatic test_zero_len();
    run_txn($urandom, $urandom, 4'd0, 4'd0, 0, "zero_len");
  endtask

  task automatic test_busy_reject();
    run_txn(32'h00C3_5A96, 32'h0000_7E81, 4'd3, 4'd2, 10, "busy_reject");
    run_txn(32'h0000_1122, 32'h0000_0033, 4'd2, 4'd1, -1, "done_reject");
  endtask

  task automatic test_reset_mid_shift();
    int c;
    @(negedge clk);
    bus.start = 1'b1; bus.address_i = $urandom; bus.data_i = $urandom;
    bus.add_nbyte = 4'd2; bus.data_nbyte = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    while (c < 40) begin @(negedge clk); c++; end
    checks++;
    if (bus.spi_cs !== 1'b1) begin errors++; $display("FAIL rst_mid precondition: cs=%b expected 1", bus.spi_cs); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sclk !== 1'b0 || bus.spi_cs !== 1'b0 || bus.mosi !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rx_data !== 32'h0)
      begin errors++; $display("FAIL rst_mid outputs: sclk=%b cs=%b mosi=%b busy=%b done=%b rx=%h expected all 0", bus.sclk, bus.spi_cs, bus.mosi, bus.busy, bus.done, bus.rx_data); end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.spi_cs !== 1'b0)
        begin errors++; $display("FAIL rst_mid held: done=%b cs=%b expected 0 0", bus.done, bus.spi_cs); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(32'hDEAD_0001, 32'h0000_4455, 4'd1, 4'd3, 0, "after_reset");
  endtask

  task automatic test_rx_loopback();
    run_txn(32'h0, 32'h0000_BEEF, 4'd0, 4'd2, 0, "rx_loopback");
    checks++;
`ifdef SPI_MASTER_RX_EN
    if (bus.rx_data !== 32'h0000_BEEF) begin errors++; $display("FAIL rx_beef: got %h expected 0000beef", bus.rx_data); end
`else
    if (bus.rx_data !== 32'h0) begin errors++; $display("FAIL rx_disabled: got %h expected 0", bus.rx_data); end
`endif
  endtask

  task automatic test_random();
    int mode;
    for (int k = 0; k < 10; k++) begin
      mode = $urandom_range(0, 2);
      run_txn($urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              (mode == 0) ? 0 : ((mode == 1) ? -1 : -2), "random");
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.add_nbyte = 4'd0; bus.data_nbyte = 4'd0;
    bus.address_i = 32'h0; bus.data_i = 32'h0;
    test_reset();
    test_defaults();
    test_clamp();
    test_zero_len();
    test_busy_reject();
    test_reset_mid_shift();
    test_rx_loopback();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
